// File: rtl/img_loader.sv
// -----------------------------------------------------------------------------
// img_loader
//   Accepts a 128x128 8-bit image streamed in raster order and writes it into
//   the image RAM, then hands the resident frame to the median filter engine
//   and waits for the engine to finish before loading the next frame.
//
// Ports
//   clk         : single clock, rising edge
//   reset       : synchronous, active-low reset
//   s_valid     : upstream pixel present on s_data
//   s_data      : upstream pixel value (raster order)
//   s_ready     : loader accepts a pixel this cycle (LOAD only)
//   waddr       : image RAM write address (pixel index)
//   wdata       : image RAM write data
//   we          : image RAM write enable, one cycle after acceptance
//   ready       : full frame resident, to the median filter engine
//   busy        : median filter engine is processing
//   frame_cnt   : frames handed off, modulo 256
//   cksum       : (IMG_LOADER_CKSUM_EN) sum of accepted pixels, modulo 2^16
//   cksum_valid : (IMG_LOADER_CKSUM_EN) cksum is final; mirrors ready
//
// Optional feature macro: IMG_LOADER_CKSUM_EN
// -----------------------------------------------------------------------------
module img_loader (
    input  logic        clk,
    input  logic        reset,
    input  logic        s_valid,
    input  logic [7:0]  s_data,
    output logic        s_ready,
    output logic [13:0] waddr,
    output logic [7:0]  wdata,
    output logic        we,
    output logic        ready,
    input  logic        busy,
    output logic [7:0]  frame_cnt
`ifdef IMG_LOADER_CKSUM_EN
    ,
    output logic [15:0] cksum,
    output logic        cksum_valid
`endif
);

    localparam logic [1:0] LOAD      = 2'd0;
    localparam logic [1:0] HANDOFF   = 2'd1;
    localparam logic [1:0] WAIT_DONE = 2'd2;

    localparam logic [13:0] LAST_INDEX = 14'h3FFF;

    logic [1:0]  state;
    logic [13:0] index;
    logic        accept;

    // Gated with reset so s_ready is low for the whole time reset is held,
    // even though the state register already sits in LOAD.
    assign s_ready = reset && (state == LOAD);
    assign accept  = s_valid && s_ready;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= LOAD;
            index     <= '0;
            we        <= 1'b0;
            waddr     <= '0;
            wdata     <= '0;
            ready     <= 1'b0;
            frame_cnt <= '0;
        end else begin
            we <= accept;
            if (accept) begin
                waddr <= index;
                wdata <= s_data;
                index <= index + 14'd1;
            end

            // ready rises the cycle after entering HANDOFF, i.e. the cycle
            // after the final write, and falls on the edge busy is seen.
            ready <= (state == HANDOFF) && !busy;

            case (state)
                LOAD: begin
                    if (accept && (index == LAST_INDEX)) begin
                        state <= HANDOFF;
                    end
                end
                HANDOFF: begin
                    if (busy) begin
                        state     <= WAIT_DONE;
                        frame_cnt <= frame_cnt + 8'd1;
                    end
                end
                WAIT_DONE: begin
                    if (!busy) begin
                        state <= LOAD;
                    end
                end
                default: begin
                    state <= LOAD;
                end
            endcase
        end
    end

`ifdef IMG_LOADER_CKSUM_EN
    // No pixel is accepted outside LOAD, so the sum is frozen while ready=1.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cksum <= '0;
        end else if ((state == WAIT_DONE) && !busy) begin
            cksum <= '0;
        end else if (accept) begin
            cksum <= cksum + {8'd0, s_data};
        end
    end

    assign cksum_valid = ready;
`endif

endmodule

// File: tb/tb_img_loader.sv
// -----------------------------------------------------------------------------
// tb_img_loader
//   Directed self-checking bench for img_loader. Pixels are driven and all
//   outputs checked one time unit after each rising edge.
// -----------------------------------------------------------------------------
module tb_img_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        s_valid;
    logic [7:0]  s_data;
    logic        s_ready;
    logic [13:0] waddr;
    logic [7:0]  wdata;
    logic        we;
    logic        ready;
    logic        busy;
    logic [7:0]  frame_cnt;
`ifdef IMG_LOADER_CKSUM_EN
    logic [15:0] cksum;
    logic        cksum_valid;
`endif

    int unsigned checks   = 0;
    int unsigned failures = 0;

    img_loader dut (
        .clk       (clk),
        .reset     (reset),
        .s_valid   (s_valid),
        .s_data    (s_data),
        .s_ready   (s_ready),
        .waddr     (waddr),
        .wdata     (wdata),
        .we        (we),
        .ready     (ready),
        .busy      (busy),
        .frame_cnt (frame_cnt)
`ifdef IMG_LOADER_CKSUM_EN
        ,
        .cksum       (cksum),
        .cksum_valid (cksum_valid)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Streams pixels for addresses start..start+count-1 and checks every
    // write one cycle after its acceptance. Pixel data is the address low
    // byte, or 0xFF when ff is set. With gaps set, s_valid toggles each cycle.
    task automatic push(input int unsigned start, input int unsigned count,
                        input bit gaps, input bit ff);
        int unsigned n        = 0;
        int unsigned cyc      = 0;
        int unsigned writes   = 0;
        bit          prev_acc = 1'b0;
        bit          acc;
        bit          full     = ((start + count) == 16384);
        logic [13:0] prev_addr = '0;
        logic [7:0]  prev_data = '0;
        logic [13:0] addr;
        while ((n < count) || prev_acc) begin
            check("we", {31'd0, we}, {31'd0, prev_acc});
            if (prev_acc) begin
                check("waddr", {18'd0, waddr}, {18'd0, prev_addr});
                check("wdata", {24'd0, wdata}, {24'd0, prev_data});
                writes++;
            end
            check("ready_low_during_load", {31'd0, ready}, 32'd0);
            check("s_ready_load", {31'd0, s_ready},
                  {31'd0, !(full && (n == count))});
            addr = 14'(start + n);
            if (n < count) begin
                s_valid = !gaps || ((cyc % 2) == 0);
                s_data  = ff ? 8'hFF : addr[7:0];
            end else begin
                // Final-write cycle: after a full frame the loader is in
                // HANDOFF and must ignore this pixel.
                s_valid = full;
                s_data  = 8'hAA;
            end
            acc = (n < count) && s_valid;
            step();
            prev_acc = acc;
            if (acc) begin
                prev_addr = addr;
                prev_data = s_data;
                n++;
            end
            cyc++;
        end
        s_valid = 1'b0;
        check("we_idle_after_stream", {31'd0, we}, 32'd0);
        check("write_count", writes, count);
    endtask

    // Expects ready=1 now; raises busy after 'delay' cycles, holds it for
    // 'hold' sampled edges, then drops it and expects return to LOAD.
    task automatic handoff(input int unsigned delay, input int unsigned hold,
                           input logic [7:0] exp_cnt, input logic [15:0] exp_ck);
        check("ready_after_last_write", {31'd0, ready}, 32'd1);
        check("s_ready_handoff", {31'd0, s_ready}, 32'd0);
`ifdef IMG_LOADER_CKSUM_EN
        check("cksum_valid", {31'd0, cksum_valid}, 32'd1);
        check("cksum", {16'd0, cksum}, {16'd0, exp_ck});
`else
        if (exp_ck != exp_ck) check("unused_ck", 32'd0, 32'd1);
`endif
        for (int i = 0; i < int'(delay); i++) begin
            step();
            check("ready_held", {31'd0, ready}, 32'd1);
        end
        busy    = 1'b1;
        s_valid = 1'b1;
        s_data  = 8'h55;
        step();
        check("ready_drop_on_busy", {31'd0, ready}, 32'd0);
        check("frame_cnt_inc", {24'd0, frame_cnt}, {24'd0, exp_cnt});
        check("s_ready_wait", {31'd0, s_ready}, 32'd0);
`ifdef IMG_LOADER_CKSUM_EN
        check("cksum_valid_drop", {31'd0, cksum_valid}, 32'd0);
`endif
        for (int i = 1; i < int'(hold); i++) begin
            step();
            check("s_ready_busy", {31'd0, s_ready}, 32'd0);
            check("we_busy", {31'd0, we}, 32'd0);
            check("ready_busy", {31'd0, ready}, 32'd0);
        end
        busy    = 1'b0;
        s_valid = 1'b0;
        step();
        check("s_ready_reload", {31'd0, s_ready}, 32'd1);
        check("frame_cnt_held", {24'd0, frame_cnt}, {24'd0, exp_cnt});
        check("we_after_wait", {31'd0, we}, 32'd0);
`ifdef IMG_LOADER_CKSUM_EN
        check("cksum_cleared", {16'd0, cksum}, 32'd0);
`endif
    endtask

    task automatic check_reset_values();
        check("rst_s_ready", {31'd0, s_ready}, 32'd0);
        check("rst_we", {31'd0, we}, 32'd0);
        check("rst_waddr", {18'd0, waddr}, 32'd0);
        check("rst_wdata", {24'd0, wdata}, 32'd0);
        check("rst_ready", {31'd0, ready}, 32'd0);
        check("rst_frame_cnt", {24'd0, frame_cnt}, 32'd0);
`ifdef IMG_LOADER_CKSUM_EN
        check("rst_cksum", {16'd0, cksum}, 32'd0);
        check("rst_cksum_valid", {31'd0, cksum_valid}, 32'd0);
`endif
    endtask

    initial begin
        // Power-on reset
        reset   = 1'b0;
        s_valid = 1'b0;
        s_data  = 8'h00;
        busy    = 1'b0;
        step();
        step();
        check_reset_values();
        reset = 1'b1;
        step();
        check("s_ready_after_reset", {31'd0, s_ready}, 32'd1);

        // busy in LOAD is ignored
        busy = 1'b1;
        step();
        step();
        check("busy_in_load_s_ready", {31'd0, s_ready}, 32'd1);
        check("busy_in_load_frame_cnt", {24'd0, frame_cnt}, 32'd0);
        check("busy_in_load_ready", {31'd0, ready}, 32'd0);
        busy = 1'b0;
        step();

        // Frame 1: continuous; sum of low bytes is 64*32640 mod 2^16 = 0xE000
        push(0, 16384, 1'b0, 1'b0);
        handoff(5, 100, 8'd1, 16'hE000);

        // Frame 2: s_valid toggled every other cycle, starts at address 0
        push(0, 16384, 1'b1, 1'b0);
        handoff(2, 3, 8'd2, 16'hE000);

        // Reset after 1000 pixels discards the partial frame
        push(0, 1000, 1'b0, 1'b0);
        reset = 1'b0;
        s_valid = 1'b1;
        s_data  = 8'h77;
        step();
        check_reset_values();
        s_valid = 1'b0;
        reset   = 1'b1;
        step();
        check("s_ready_after_mid_reset", {31'd0, s_ready}, 32'd1);
        push(0, 16384, 1'b0, 1'b0);
        handoff(1, 1, 8'd1, 16'hE000);

        // frame_cnt wrap: preload the counter to 255 and the index near the
        // end of the frame, then finish the frame with the last four pixels.
        dut.frame_cnt = 8'd255;
        dut.index     = 14'd16380;
        step();
        push(16380, 4, 1'b0, 1'b0);
        handoff(1, 2, 8'd0, 16'h03F6);

        // The index wrapped 16383->0, so a fresh partial load starts at 0
        push(0, 3, 1'b0, 1'b0);

`ifdef IMG_LOADER_CKSUM_EN
        // All-0xFF frame: 16384*255 mod 2^16 = 0xC000
        reset = 1'b0;
        step();
        reset = 1'b1;
        step();
        push(0, 16384, 1'b0, 1'b1);
        handoff(3, 4, 8'd1, 16'hC000);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Guard against a stalled run
    initial begin
        #2000000;
        $display("FAIL timeout observed=running expected=finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/img_loader.md
IMG_LOADER -- requirements
Module: img_loader

Interface
REQ-001 The block SHALL have the port clk, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-002 The block SHALL have the port reset, input, 1 bit: synchronous, active-low reset, sampled on the rising edge of clk.
REQ-003 The block SHALL have the port s_valid, input, 1 bit: an upstream pixel is present on s_data.
REQ-004 The block SHALL have the port s_data, input, 8 bits: the upstream pixel value, 128x128 raster order.
REQ-005 The block SHALL have the port s_ready, output, 1 bit: the loader accepts a pixel this cycle.
REQ-006 The block SHALL have the port waddr, output, 14 bits: the image RAM write address.
REQ-007 The block SHALL have the port wdata, output, 8 bits: the image RAM write data.
REQ-008 The block SHALL have the port we, output, 1 bit: the image RAM write enable, active high.
REQ-009 The block SHALL have the port ready, output, 1 bit: a full frame is resident, driven to the median filter engine.
REQ-010 The block SHALL have the port busy, input, 1 bit: the median filter engine is processing.
REQ-011 The block SHALL have the port frame_cnt, output, 8 bits: the number of frames handed off, modulo 256.

Function
REQ-012 The block SHALL implement the states LOAD, HANDOFF and WAIT_DONE, encoded in 2 bits.
REQ-013 A pixel SHALL be accepted on a rising edge where s_valid=1 and s_ready=1.
REQ-014 s_ready SHALL equal 1 only in LOAD, combinationally decoded from the state.
REQ-015 The cycle after an acceptance, the block SHALL drive we=1, wdata=the accepted pixel and waddr=the pixel index.
REQ-016 we SHALL be 0 in all other cycles; the write latency is exactly 1 cycle.
REQ-017 The pixel index SHALL be a 14-bit counter that increments per acceptance and wraps 16383->0.
REQ-018 The block SHALL go LOAD->HANDOFF on the acceptance of index 16383; the final write still occurs the following cycle.
REQ-019 ready SHALL be 1 only in HANDOFF, registered, and asserted the cycle after the final write.
REQ-020 The block SHALL go HANDOFF->WAIT_DONE on the first edge where busy=1 is sampled; ready SHALL drop that edge.
REQ-021 On the HANDOFF->WAIT_DONE transition, frame_cnt SHALL increment, wrapping 255->0.
REQ-022 The block SHALL go WAIT_DONE->LOAD on the first edge where busy=0 is sampled; s_ready rises the following cycle.
REQ-023 s_valid SHALL be ignored outside LOAD; no write occurs and the index is held.
REQ-024 A gap in s_valid during LOAD SHALL stall the index with no write; there is no timeout.
REQ-025 busy=1 sampled in LOAD SHALL be ignored; it is a protocol violation with no state change.

Reset
REQ-026 When reset=0 at an edge: state=LOAD, index=0, we=0, waddr=0, wdata=0, ready=0, frame_cnt=0.
REQ-027 A reset mid-frame or mid-handoff SHALL discard the partial frame; the next acceptance writes address 0.
REQ-028 s_ready SHALL be 0 while reset=0 and 1 on the first cycle after reset releases.

Configuration
REQ-029 The macro IMG_LOADER_CKSUM_EN SHALL, when defined, add the outputs cksum (16 bits) and cksum_valid (1 bit).
REQ-030 With the macro defined, cksum SHALL accumulate each accepted pixel modulo 2^16 and clear at reset and at each LOAD entry.
REQ-031 With the macro defined, cksum_valid SHALL equal ready, and cksum SHALL be stable while cksum_valid=1.
REQ-032 With the macro undefined, the ports and accumulator SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-033 A bench SHALL cover: continuous 16384 pixels with s_data=index[7:0] -> writes addr 0..16383 with matching data, each 1 cycle after accept, and ready=1 the cycle after the last write.
REQ-034 A bench SHALL cover: s_valid toggled every other cycle -> exactly 16384 writes, no duplicate addresses, and the same final RAM image.
REQ-035 A bench SHALL cover: ready=1, busy raised 5 cycles later -> ready falls on that edge and frame_cnt goes 0->1; busy held 100 cycles then dropped -> s_ready=1 the next cycle and the next write targets address 0.
REQ-036 A bench SHALL cover: reset=0 after 1000 pixels -> all outputs at reset values; reload of 16384 pixels completes normally.
REQ-037 A bench SHALL cover: 256 complete frames -> frame_cnt wraps to 0.
REQ-038 A bench SHALL cover, with IMG_LOADER_CKSUM_EN defined: all pixels 0xFF -> cksum=0xC000 (16384*255 mod 65536) with cksum_valid=1.
